// File: rtl/param_cpu_pkg.sv
// Shared definitions for param_cpu: opcode map, instruction field positions,
// FSM state encoding and the flag bundle.
package param_cpu_pkg;

    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 27;
    localparam int RDST_HI = 26;
    localparam int RDST_LO = 22;
    localparam int RS1_HI  = 21;
    localparam int RS1_LO  = 17;
    localparam int IMM_BIT = 16;
    localparam int RS2_HI  = 15;
    localparam int RS2_LO  = 11;
    localparam int ISRC_HI = 15;

    typedef enum logic [4:0] {
        OP_MOVSGPR  = 5'b00000,
        OP_MOV      = 5'b00001,
        OP_ADD      = 5'b00010,
        OP_SUB      = 5'b00011,
        OP_MUL      = 5'b00100,
        OP_OR       = 5'b00101,
        OP_AND      = 5'b00110,
        OP_XOR      = 5'b00111,
        OP_XNOR     = 5'b01000,
        OP_NAND     = 5'b01001,
        OP_NOR      = 5'b01010,
        OP_NOT      = 5'b01011,
        OP_STOREREG = 5'b01100,
        OP_STOREDIN = 5'b01101,
        OP_SENDOUT  = 5'b01110,
        OP_SENDREG  = 5'b01111,
        OP_JUMP     = 5'b10000,
        OP_JC       = 5'b10001,
        OP_JNC      = 5'b10010,
        OP_JSIGN    = 5'b10011,
        OP_JNSIGN   = 5'b10100,
        OP_JZ       = 5'b10101,
        OP_JNZ      = 5'b10110,
        OP_JOF      = 5'b10111,
        OP_JNOF     = 5'b11000,
        OP_HALT     = 5'b11001
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_EXEC    = 3'd2,
        ST_WAIT_IN = 3'd3,
        ST_HALT    = 3'd4
    } state_e;

    typedef struct packed {
        logic zero;
        logic sign;
        logic carry;
        logic ovf;
    } flags_t;

endpackage

// File: rtl/param_cpu_alu.sv
// Combinational ALU: arithmetic/logic result, high product half and flags.
module param_cpu_alu
    import param_cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  opcode_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] res,
    output logic [DATA_W-1:0] hi,
    output flags_t            flags,
    output logic              flags_we
);
    localparam int M = DATA_W - 1;

    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     dif;
    logic [2*DATA_W-1:0] prod;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign dif  = {1'b0, a} - {1'b0, b};
    assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

    always_comb begin
        res      = '0;
        hi       = '0;
        flags    = '0;
        flags_we = 1'b1;
        case (op)
            OP_ADD: begin
                res         = sum[M:0];
                flags.carry = sum[DATA_W];
                flags.ovf   = (a[M] == b[M]) && (res[M] != a[M]);
            end
            OP_SUB: begin
                // the extra bit of the widened difference is the unsigned borrow
                res         = dif[M:0];
                flags.carry = dif[DATA_W];
                flags.ovf   = (a[M] != b[M]) && (res[M] != a[M]);
            end
            OP_MUL:  {hi, res} = prod;
            OP_OR:   res = a | b;
            OP_AND:  res = a & b;
            OP_XOR:  res = a ^ b;
            OP_XNOR: res = ~(a ^ b);
            OP_NAND: res = ~(a & b);
            OP_NOR:  res = ~(a | b);
            OP_NOT:  res = ~a;
            default: flags_we = 1'b0;
        endcase
        flags.zero = (op == OP_MUL) ? (prod == '0) : (res == '0);
        flags.sign = (op == OP_MUL) ? prod[2*DATA_W-1] : res[M];
    end

endmodule

// File: rtl/param_cpu.sv
// Multi-cycle parameterised processor: FETCH/EXEC loop over a loadable
// instruction memory, GPR file, data memory and a din/dout handshake.
module param_cpu
    import param_cpu_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NREGS      = 32,
    parameter int IMEM_DEPTH = 32,
    parameter int DMEM_DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          sys_rst,
    input  logic                          start,
    input  logic                          prog_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
    input  logic [31:0]                   prog_data,
    input  logic [DATA_W-1:0]             din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic [DATA_W-1:0]             dout,
    output logic                          dout_valid,
    output logic                          halted,
    output logic [$clog2(IMEM_DEPTH)-1:0] pc
);
    localparam int PC_W = $clog2(IMEM_DEPTH);
    localparam int DA_W = $clog2(DMEM_DEPTH);
    localparam int RI_W = $clog2(NREGS);

    logic [31:0]       imem [IMEM_DEPTH];
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] gpr_q [NREGS];
    logic [DATA_W-1:0] gpr_d [NREGS];
    logic [DATA_W-1:0] sgpr_q, sgpr_d, dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    flags_t            flags_q, flags_d;

    opcode_e           op;
    logic [RI_W-1:0]   rd, rs1, rs2;
    logic [DATA_W-1:0] imm, opa, opb, alu_res, alu_hi, dmem_wdata;
    logic [DA_W-1:0]   daddr;
    logic [PC_W-1:0]   jtgt;
    flags_t            alu_flags;
    logic              alu_flags_we, jtaken, dmem_we;

    // register fields are 5 bits wide; fold them into the implemented GPR range
    assign op    = opcode_e'(ir_q[OPC_HI:OPC_LO]);
    assign rd    = RI_W'({1'b0, ir_q[RDST_HI:RDST_LO]} % 6'(NREGS));
    assign rs1   = RI_W'({1'b0, ir_q[RS1_HI:RS1_LO]} % 6'(NREGS));
    assign rs2   = RI_W'({1'b0, ir_q[RS2_HI:RS2_LO]} % 6'(NREGS));
    assign imm   = DATA_W'(ir_q[ISRC_HI:0]);
    assign daddr = ir_q[DA_W-1:0];
    assign jtgt  = ir_q[PC_W-1:0];
    assign opa   = gpr_q[rs1];
    assign opb   = ir_q[IMM_BIT] ? imm : gpr_q[rs2];

    param_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op       (op),
        .a        (opa),
        .b        (opb),
        .res      (alu_res),
        .hi       (alu_hi),
        .flags    (alu_flags),
        .flags_we (alu_flags_we)
    );

    always_comb begin
        jtaken = 1'b0;
        case (op)
            OP_JUMP:   jtaken = 1'b1;
            OP_JC:     jtaken = flags_q.carry;
            OP_JNC:    jtaken = !flags_q.carry;
            OP_JSIGN:  jtaken = flags_q.sign;
            OP_JNSIGN: jtaken = !flags_q.sign;
            OP_JZ:     jtaken = flags_q.zero;
            OP_JNZ:    jtaken = !flags_q.zero;
            OP_JOF:    jtaken = flags_q.ovf;
            OP_JNOF:   jtaken = !flags_q.ovf;
            default:   jtaken = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        gpr_d        = gpr_q;
        sgpr_d       = sgpr_q;
        flags_d      = flags_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        dmem_we      = 1'b0;
        dmem_wdata   = din;
        case (state_q)
            ST_IDLE, ST_HALT: if (start) state_d = ST_FETCH;
            ST_FETCH: begin
                ir_d    = imem[pc_q];
                pc_d    = pc_q + PC_W'(1);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                if (alu_flags_we) begin
                    gpr_d[rd] = alu_res;
                    flags_d   = alu_flags;
                    if (op == OP_MUL) sgpr_d = alu_hi;
                end
                if (jtaken) pc_d = jtgt;
                case (op)
                    OP_MOV:      gpr_d[rd] = opb;
                    OP_MOVSGPR:  gpr_d[rd] = sgpr_q;
                    OP_STOREREG: begin
                        dmem_we    = 1'b1;
                        dmem_wdata = opa;
                    end
                    OP_STOREDIN: begin
                        if (din_valid) dmem_we = 1'b1;
                        else           state_d = ST_WAIT_IN;
                    end
                    OP_SENDOUT: begin
                        dout_d       = dmem[daddr];
                        dout_valid_d = 1'b1;
                    end
                    OP_SENDREG:  gpr_d[rd] = dmem[daddr];
                    OP_HALT:     state_d = ST_HALT;
                    default:     ;
                endcase
            end
            ST_WAIT_IN: begin
                if (din_valid) begin
                    dmem_we = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            ir_q         <= '0;
            sgpr_q       <= '0;
            flags_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) gpr_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            sgpr_q       <= sgpr_d;
            flags_q      <= flags_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            gpr_q        <= gpr_d;
        end
    end

    // memories keep their contents across reset
    always_ff @(posedge clk) begin
        if (prog_we && (state_q == ST_IDLE || state_q == ST_HALT)) imem[prog_addr] <= prog_data;
        if (dmem_we && !sys_rst) dmem[daddr] <= dmem_wdata;
    end

    assign din_ready  = (state_q == ST_WAIT_IN) || (state_q == ST_EXEC && op == OP_STOREDIN);
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign halted     = (state_q == ST_HALT);
    assign pc         = pc_q;

endmodule

// File: tb/tb_param_cpu.sv
// Directed bench for param_cpu: small hand-assembled programs with
// hand-computed register, flag, memory and handshake results.
module tb_param_cpu;
    import param_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        sys_rst, start, prog_we, din_valid, din_ready, dout_valid, halted;
    logic [4:0]  prog_addr, pc;
    logic [31:0] prog_data;
    logic [15:0] din, dout;
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          saw_wrap;
    int          wait_cnt;

    always #5 clk = ~clk;

    param_cpu #(.DATA_W(16), .NREGS(32), .IMEM_DEPTH(32), .DMEM_DEPTH(32)) dut (
        .clk        (clk),
        .sys_rst    (sys_rst),
        .start      (start),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .halted     (halted),
        .pc         (pc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ins(opcode_e op, int rd, int rs1, logic im, logic [15:0] v);
        return {op, 5'(rd), 5'(rs1), im, v};
    endfunction

    function automatic logic [31:0] rr(opcode_e op, int rd, int rs1, int rs2);
        return {op, 5'(rd), 5'(rs1), 1'b0, 5'(rs2), 11'b0};
    endfunction

    task automatic load(input int a, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = 5'(a); prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        logic [4:0] prev;
        prev = pc;
        saw_wrap = 1'b0;
        for (int i = 0; i < 200 && !halted; i++) begin
            @(negedge clk);
            if (prev == 5'd31 && pc == 5'd0) saw_wrap = 1'b1;
            prev = pc;
        end
        check({tag, "_halted"}, 32'(halted), 32'd1);
    endtask

    initial begin
        sys_rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        din = '0; din_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        sys_rst = 1'b0;

        check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_din_ready", 32'(din_ready), 32'd0);
        check("rst_dout", {dout_valid, 15'd0, dout}, 32'd0);

        // add overflow into the sign bit
        load(0, ins(OP_MOV, 1, 0, 1'b1, 16'h7FFF));
        load(1, ins(OP_ADD, 2, 1, 1'b1, 16'h0001));
        load(2, ins(OP_HALT, 0, 0, 1'b0, 16'h0));
        go();
        wait_halt("add");
        check("add_r2", 32'(dut.gpr_q[2]), 32'h8000);
        check("add_flags_zsco", 32'(dut.flags_q), 32'b0100 | 32'b0001);

        // sub with borrow, then jc taken
        do_reset();
        load(0, ins(OP_MOV, 1, 0, 1'b1, 16'h0003));
        load(1, ins(OP_SUB, 2, 1, 1'b1, 16'h0005));
        load(2, ins(OP_JC, 0, 0, 1'b0, 16'd7));
        load(3, ins(OP_MOV, 5, 0, 1'b1, 16'h0001));
        load(4, ins(OP_HALT, 0, 0, 1'b0, 16'h0));
        load(7, ins(OP_HALT, 0, 0, 1'b0, 16'h0));
        go();
        wait_halt("sub");
        check("sub_r2", 32'(dut.gpr_q[2]), 32'hFFFE);
        check("sub_carry", 32'(dut.flags_q.carry), 32'd1);
        check("sub_ovf", 32'(dut.flags_q.ovf), 32'd0);
        check("jc_pc", 32'(pc), 32'd8);
        check("jc_skipped_r5", 32'(dut.gpr_q[5]), 32'd0);

        // mul low/high halves and movsgpr
        do_reset();
        load(0, ins(OP_MOV, 1, 0, 1'b1, 16'h1234));
        load(1, ins(OP_MOV, 2, 0, 1'b1, 16'h0100));
        load(2, rr(OP_MUL, 3, 1, 2));
        load(3, ins(OP_MOVSGPR, 4, 0, 1'b0, 16'h0));
        load(4, ins(OP_HALT, 0, 0, 1'b0, 16'h0));
        go();
        wait_halt("mul");
        check("mul_r3", 32'(dut.gpr_q[3]), 32'h3400);
        check("mul_sgpr", 32'(dut.sgpr_q), 32'h0012);
        check("movsgpr_r4", 32'(dut.gpr_q[4]), 32'h0012);

        // storedin stall, then sendout
        do_reset();
        load(0, ins(OP_STOREDIN, 0, 0, 1'b0, 16'd5));
        load(1, ins(OP_SENDOUT, 0, 0, 1'b0, 16'd5));
        load(2, ins(OP_HALT, 0, 0, 1'b0, 16'h0));
        go();
        for (int i = 0; i < 20 && !din_ready; i++) @(negedge clk);
        check("sd_ready_exec", 32'(din_ready), 32'd1);
        check("sd_state_exec", 32'(dut.state_q), 32'(ST_EXEC));
        wait_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (dut.state_q == ST_WAIT_IN && din_ready) wait_cnt++;
        end
        check("sd_wait_cycles", 32'(wait_cnt), 32'd4);
        din = 16'hA5A5; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        check("sd_state_after", 32'(dut.state_q), 32'(ST_FETCH));
        check("sd_ready_after", 32'(din_ready), 32'd0);
        check("sd_dmem5", 32'(dut.dmem[5]), 32'hA5A5);
        for (int i = 0; i < 20 && !dout_valid; i++) @(negedge clk);
        check("so_valid", 32'(dout_valid), 32'd1);
        check("so_dout", 32'(dout), 32'hA5A5);
        @(negedge clk);
        check("so_valid_pulse", 32'(dout_valid), 32'd0);
        wait_halt("so");

        // pc wrap through the last imem word, halt and resume
        do_reset();
        load(0, ins(OP_JZ, 0, 0, 1'b0, 16'd3));
        load(1, ins(OP_JUMP, 0, 0, 1'b0, 16'd31));
        load(3, ins(OP_HALT, 0, 0, 1'b0, 16'h0));
        load(4, ins(OP_MOV, 8, 0, 1'b1, 16'h0011));
        load(5, ins(OP_HALT, 0, 0, 1'b0, 16'h0));
        load(31, ins(OP_ADD, 6, 0, 1'b1, 16'h0000));
        go();
        wait_halt("wrap");
        check("wrap_seen", 32'(saw_wrap), 32'd1);
        check("wrap_halt_pc", 32'(pc), 32'd4);
        go();
        check("resume_halted", 32'(halted), 32'd0);
        wait_halt("resume");
        check("resume_r8", 32'(dut.gpr_q[8]), 32'h0011);
        check("resume_pc", 32'(pc), 32'd6);

        // reset while stalled in WAIT_IN
        do_reset();
        load(0, ins(OP_MOV, 1, 0, 1'b1, 16'h0077));
        load(1, ins(OP_SENDOUT, 0, 0, 1'b0, 16'd5));
        load(2, ins(OP_STOREDIN, 0, 0, 1'b0, 16'd9));
        load(3, ins(OP_HALT, 0, 0, 1'b0, 16'h0));
        go();
        for (int i = 0; i < 40 && dut.state_q != ST_WAIT_IN; i++) @(negedge clk);
        check("wr_state", 32'(dut.state_q), 32'(ST_WAIT_IN));
        check("wr_dout", 32'(dout), 32'hA5A5);
        check("wr_r1", 32'(dut.gpr_q[1]), 32'h0077);
        load(2, 32'hDEAD_BEEF);
        do_reset();
        check("wr_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("wr_rst_pc", 32'(pc), 32'd0);
        check("wr_rst_outs", {28'd0, din_ready, dout_valid, halted, 1'b0}, 32'd0);
        check("wr_rst_dout", 32'(dout), 32'd0);
        check("wr_rst_ir", dut.ir_q, 32'd0);
        check("wr_rst_r1", 32'(dut.gpr_q[1]), 32'd0);
        check("wr_rst_flags", 32'(dut.flags_q), 32'd0);
        check("wr_imem_kept", dut.imem[2], ins(OP_STOREDIN, 0, 0, 1'b0, 16'd9));
        check("wr_dmem_kept", 32'(dut.dmem[5]), 32'hA5A5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/param_cpu.md
PARAM_CPU -- requirements
Module: param_cpu

Interface
REQ-001 SHALL have parameter DATA_W, default 16, datapath/GPR/data-memory word width, legal values 16 or 32.
REQ-002 SHALL have parameter NREGS, default 32, GPR count, legal 2..32.
REQ-003 SHALL have parameter IMEM_DEPTH, default 32, 32-bit instruction words, power of two.
REQ-004 SHALL have parameter DMEM_DEPTH, default 32, data words, power of two.
REQ-005 SHALL have clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have sys_rst  in  1  reset; synchronous and active-high.
REQ-007 SHALL have start  in  1  leave IDLE or HALT.
REQ-008 SHALL have prog_we  in  1; prog_addr  in  log2(IMEM_DEPTH); prog_data  in  32  instruction-memory load port.
REQ-009 SHALL have din  in  DATA_W; din_valid  in  1; din_ready  out  1  input handshake.
REQ-010 SHALL have dout  out  DATA_W; dout_valid  out  1  output strobe.
REQ-011 SHALL have halted  out  1; pc  out  log2(IMEM_DEPTH)  current program counter.

Function
REQ-012 SHALL decode IR as opcode[31:27], rdst[26:22], rsrc1[21:17], imm_mode[16], rsrc2[15:11], isrc[15:0]; isrc zero-extended to DATA_W; register indices taken modulo NREGS.
REQ-013 SHALL use states IDLE, FETCH, EXEC, WAIT_IN, HALT.
REQ-014 SHALL go IDLE->FETCH when start=1; otherwise remain in IDLE.
REQ-015 SHALL in FETCH load IR<=imem[pc], pc<=pc+1 mod IMEM_DEPTH (wraps to 0), then go EXEC; 2 cycles per instruction except storedin stalls and halt.
REQ-016 SHALL in EXEC perform the opcode, then go FETCH, except halt->HALT and storedin without din_valid->WAIT_IN.
REQ-017 SHALL implement mov (imm or reg), movsgpr (GPR[rdst]<=SGPR), add, sub, mul, or, and, xor, xnor, nand, nor (01010), not, with opcode codes unchanged from the current processor.
REQ-018 SHALL for mul form the 2*DATA_W product; GPR[rdst]<=low half, SGPR<=high half.
REQ-019 SHALL update flags only on add, sub, mul and logic ops, in the same EXEC cycle: zero = result==0 (mul: full product), sign = result MSB (mul: product MSB).
REQ-020 SHALL set carry = carry-out on add, borrow (a<b unsigned) on sub, 0 otherwise; overflow = two's-complement overflow on add/sub using the DATA_W second operand (register or extended immediate), 0 otherwise.
REQ-021 SHALL implement storereg dmem[isrc]<=GPR[rsrc1], sendreg GPR[rdst]<=dmem[isrc], sendout dout<=dmem[isrc] with dout_valid=1 for exactly one cycle; data addresses taken modulo DMEM_DEPTH.
REQ-022 SHALL for storedin assert din_ready in EXEC and WAIT_IN; transfer on din_valid&din_ready writes dmem[isrc]<=din and goes FETCH; WAIT_IN holds indefinitely otherwise.
REQ-023 SHALL implement jump and conditional jumps jc/jnc/jsign/jnsign/jz/jnz/jof/jnof as pc<=isrc mod IMEM_DEPTH when taken; jumps never modify flags.
REQ-024 SHALL in HALT assert halted; start=1 resumes at FETCH with pc unchanged.
REQ-025 SHALL treat undefined opcodes (11010-11111) as no-ops.
REQ-026 SHALL accept prog_we writes only in IDLE or HALT; ignore them elsewhere.

Reset
REQ-027 SHALL on sys_rst=1 at a clock edge force state IDLE, pc=0, IR=0, all GPRs=0, SGPR=0, flags=0, dout=0, dout_valid=0, din_ready=0, halted=0, regardless of state (including mid-WAIT_IN).
REQ-028 SHALL NOT clear instruction or data memory on reset.

Structure
REQ-029 SHALL place opcode constants, IR field positions and state encoding in shared package param_cpu_pkg.
REQ-030 SHALL implement ALU and flag generation as combinational sub-module param_cpu_alu.

Verification
REQ-031 SHALL test: program mov r1,#0x7FFF; add r2,r1,#1 -> r2=0x8000, ovf=1, sign=1, carry=0, zero=0.
REQ-032 SHALL test: mov r1,#3; sub r2,r1,#5 -> r2=0xFFFE, carry(borrow)=1, ovf=0; jc 7 -> pc=7 next FETCH.
REQ-033 SHALL test: mul r3,r1,r2 with 0x1234*0x0100 -> r3=0x3400, SGPR=0x0012; movsgpr r4 -> r4=0x0012.
REQ-034 SHALL test: storedin to addr 5 with din_valid low 4 cycles then high, din=0xA5A5 -> stays WAIT_IN 4 cycles; dmem[5]=0xA5A5; sendout 5 -> dout=0xA5A5, dout_valid one cycle.
REQ-035 SHALL test: jump to IMEM_DEPTH-1 holding a non-jump, then observe pc wrap to 0; halt -> halted=1; start -> resumes at next instruction.
REQ-036 SHALL test: sys_rst asserted during WAIT_IN -> next cycle IDLE, all outputs at reset values, prior prog_we contents intact.
